cla_multiword_seq: RTL

Multi-cycle sequencer for wide additions using one `cla` instance of width `Ancho`. It captures two `Ancho*Palabras`-bit operands and a carry-in, then feeds the adder one `Ancho`-bit chunk per cycle, least significant chunk first. Each chunk's carry is registered and chained into the next chunk. The full sum and final carry are returned through a valid/ready output handshake. It sits directly upstream of `cla`, drives its `A`, `B` and `Cin`, and consumes its `S`.

---
 rtl/cla_pkg.sv | 6 +
 rtl/cla.sv | 34 +++
 rtl/cla_multiword_seq.sv | 88 ++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// cla_pkg: shared state encoding and default sizes for the multiword CLA sequencer.
package cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
  localparam int ANCHO_DEF = 8;
  localparam int PALABRAS_DEF = 4;
endpackage

// File: rtl/cla.sv
// cla: Ancho-bit carry-lookahead adder; S[Ancho] carries the final carry, mirrored on Cout.
module cla #(
  parameter int Ancho = 8
) (
  input  logic [Ancho-1:0] A,
  input  logic [Ancho-1:0] B,
  input  logic             Cin,
  output logic [Ancho:0]   S,
  output logic             Cout
);
  logic [Ancho-1:0] g, p;
  logic [Ancho:0] c;
  logic acc, pp;
  assign g = A & B;
  assign p = A ^ B;
  // Each carry is expanded fully over g/p terms rather than chained.
  always_comb begin
    c = '0;
    acc = 1'b0;
    pp = 1'b0;
    c[0] = Cin;
    for (int i = 0; i < Ancho; i++) begin
      acc = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = acc | (pp & Cin);
    end
  end
  assign S = {c[Ancho], p ^ c[Ancho-1:0]};
  assign Cout = c[Ancho];
endmodule

// File: rtl/cla_multiword_seq.sv
// cla_multiword_seq: adds two Ancho*Palabras-bit operands one chunk per cycle through a
// single cla, LSB chunk first, with the chunk carry registered between cycles.
module cla_multiword_seq
  import cla_pkg::*;
#(
  parameter int Ancho = ANCHO_DEF,
  parameter int Palabras = PALABRAS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [Ancho*Palabras-1:0] A_in,
  input  logic [Ancho*Palabras-1:0] B_in,
  input  logic                      Cin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [Ancho*Palabras-1:0] S_out,
  output logic                      Cout,
  output logic                      busy
);
  localparam int W = Ancho * Palabras;
  localparam int IW = $clog2(Palabras);
  localparam logic [IW-1:0] LAST = IW'(Palabras - 1);
  seq_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [Ancho:0] cla_s;
  logic cla_cout_unused;
  cla #(.Ancho(Ancho)) u_cla (
    .A   (a_q[idx_q*Ancho +: Ancho]),
    .B   (b_q[idx_q*Ancho +: Ancho]),
    .Cin (carry_q),
    .S   (cla_s),
    .Cout(cla_cout_unused)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      carry_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      carry_q <= carry_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      cout_q <= cout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    carry_d = carry_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    cout_d = cout_q;
    if (state_q == IDLE && in_valid) begin
      a_d = A_in;
      b_d = B_in;
      carry_d = Cin_in;
      idx_d = '0;
      s_d = '0;
      cout_d = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      s_d[idx_q*Ancho +: Ancho] = cla_s[Ancho-1:0];
      carry_d = cla_s[Ancho];
      idx_d = (idx_q == LAST) ? '0 : idx_q + IW'(1);
      cout_d = (idx_q == LAST) ? cla_s[Ancho] : cout_q;
      state_d = (idx_q == LAST) ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = state_q == RUN;
  assign out_valid = state_q == DONE;
  assign S_out = s_q;
  assign Cout = cout_q;
endmodule
